// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_ISSUE = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer that parks a fetched instruction while Decode is stalled.
module fetch_hold_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_entry,
    output logic         o_full
);

    fetch_entry_t r_entry;
    logic         r_full;

    // Push and pop never coincide: pushes only happen while Decode is stalled.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_full <= 1'b0;
        end else if (i_push) begin
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry <= '0;
        end else if (i_push) begin
            r_entry <= i_entry;
        end
    end

    assign o_entry = r_entry;
    assign o_full  = r_full;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID register; single-outstanding imem requests.
// Optional FETCH_CHAIN_EN: issue the next request in the same cycle a response lands.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] w_pcf_nxt;
    logic [XLEN-1:0] w_pcf_plus4;
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_resp_take;

    logic            w_hold_push;
    logic            w_hold_pop;
    logic            w_hold_full;
    fetch_entry_t    w_hold_entry;
    fetch_entry_t    w_resp_entry;

    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;

    assign w_pcf_plus4 = r_pcf + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH_ISSUE;
            r_pcf   <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pcf   <= w_pcf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pcf_nxt   = r_pcf;
        w_req       = 1'b0;
        w_addr      = r_pcf;
        w_resp_take = 1'b0;
        case (r_state)
            FETCH_ISSUE: begin
                if (PCSrcE) begin
                    w_pcf_nxt = PCTargetE;
                end else if (!StallF && !w_hold_full) begin
                    w_req       = 1'b1;
                    w_state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid && PCSrcE) begin
                    w_pcf_nxt   = PCTargetE;
                    w_state_nxt = FETCH_ISSUE;
                end else if (imem_rvalid) begin
                    w_resp_take = 1'b1;
                    w_pcf_nxt   = w_pcf_plus4;
                    w_state_nxt = FETCH_ISSUE;
`ifdef FETCH_CHAIN_EN
                    if (!StallF && !StallD && !w_hold_full) begin
                        w_req       = 1'b1;
                        w_addr      = w_pcf_plus4;
                        w_state_nxt = FETCH_WAIT;
                    end
`endif
                end else if (PCSrcE) begin
                    w_pcf_nxt   = PCTargetE;
                    w_state_nxt = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (PCSrcE) begin
                    w_pcf_nxt = PCTargetE;
                end
                if (imem_rvalid) begin
                    w_state_nxt = FETCH_ISSUE;
                end
            end
            default: begin
                w_state_nxt = FETCH_ISSUE;
            end
        endcase
    end

    // Request outputs are forced to their idle values while reset is held.
    assign imem_req  = w_req && !reset;
    assign imem_addr = reset ? RESET_PC : w_addr;

    assign w_resp_entry = '{instr: imem_rdata, pc: r_pcf};
    assign w_hold_push  = w_resp_take && StallD && !FlushD;
    assign w_hold_pop   = w_hold_full && !StallD && !FlushD;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_hold_push),
        .i_pop   (w_hold_pop),
        .i_clear (FlushD),
        .i_entry (w_resp_entry),
        .o_entry (w_hold_entry),
        .o_full  (w_hold_full)
    );

    // IF/ID register: flush beats stall; held entry beats a fresh response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_hold_full) begin
                r_instr_d    <= w_hold_entry.instr;
                r_pc_d       <= w_hold_entry.pc;
                r_pc_plus4_d <= w_hold_entry.pc + XLEN'(4);
                r_valid_d    <= 1'b1;
            end else if (w_resp_take) begin
                r_instr_d    <= imem_rdata;
                r_pc_d       <= r_pcf;
                r_pc_plus4_d <= w_pcf_plus4;
                r_valid_d    <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc_plus4_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; the bench itself plays instruction memory.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stf, std, fld, pcs;
        logic [31:0] tgt;
        logic        rv;
        logic [31:0] rd;
        logic        creq;
        logic [31:0] caddr;
        logic [31:0] instr, pcd, pc4;
        logic        vld;
    } vec_t;

    vec_t vecs[$];

    // Memory contents are tagged with their own address so any mixup is visible.
    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(
        input logic rst, stf, std, fld, pcs, input logic [31:0] tgt,
        input logic rv, input logic [31:0] rd,
        input logic creq, input logic [31:0] caddr,
        input logic [31:0] instr, pcd, pc4, input logic vld);
        vec_t v;
        v.rst = rst; v.stf = stf; v.std = std; v.fld = fld; v.pcs = pcs;
        v.tgt = tgt; v.rv = rv; v.rd = rd; v.creq = creq; v.caddr = caddr;
        v.instr = instr; v.pcd = pcd; v.pc4 = pc4; v.vld = vld;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check request outputs mid-cycle and IF/ID after the edge.
    task automatic apply(input vec_t v, input bit chk_comb, input string id);
        @(negedge clk);
        reset = v.rst; StallF = v.stf; StallD = v.std; FlushD = v.fld;
        PCSrcE = v.pcs; PCTargetE = v.tgt; imem_rvalid = v.rv; imem_rdata = v.rd;
        #1;
        if (chk_comb) begin
            check({id, " imem_req"}, 32'(imem_req), 32'(v.creq));
            check({id, " imem_addr"}, imem_addr, v.caddr);
        end
        @(posedge clk);
        #1;
        check({id, " InstrD"}, InstrD, v.instr);
        check({id, " PCD"}, PCD, v.pcd);
        check({id, " PCPlus4D"}, PCPlus4D, v.pc4);
        check({id, " ValidD"}, 32'(ValidD), 32'(v.vld));
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; imem_rvalid = 1'b0; imem_rdata = '0;

        // rst stf std fld pcs tgt | rv rd | req addr | InstrD PCD PCPlus4D ValidD
        vecs.push_back(mk(1,0,0,0,0,32'h0,0,32'h0, 0,32'h0, NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,32'h0,0,32'h0, 0,32'h0, NOP,32'h0,32'h0,0));
        // basic latency-1 fetch: 0x0, bubble, 0x4, bubble
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h0, NOP,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'h0), 0,32'h0, tag(32'h0),32'h0,32'h4,1));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h4, NOP,32'h0,32'h4,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'h4), 0,32'h4, tag(32'h4),32'h4,32'h8,1));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h8, NOP,32'h4,32'h8,0));
        // redirect while waiting on 0x8; late response dropped
        vecs.push_back(mk(0,0,0,0,1,32'h100,0,32'h0, 0,32'h8, NOP,32'h4,32'h8,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 0,32'h100, NOP,32'h4,32'h8,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'h8), 0,32'h100, NOP,32'h4,32'h8,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h100, NOP,32'h4,32'h8,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'h100), 0,32'h100, tag(32'h100),32'h100,32'h104,1));
        // redirect in ISSUE, then redirect coincident with response at 0x10
        vecs.push_back(mk(0,0,0,0,1,32'h10,0,32'h0, 0,32'h104, NOP,32'h100,32'h104,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h10, NOP,32'h100,32'h104,0));
        vecs.push_back(mk(0,0,0,0,1,32'h200,1,tag(32'h10), 0,32'h10, NOP,32'h100,32'h104,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h200, NOP,32'h100,32'h104,0));
        vecs.push_back(mk(0,0,0,0,1,32'h20,1,tag(32'h200), 0,32'h200, NOP,32'h100,32'h104,0));
        // StallD when 0x20 returns: parked, then released
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h20, NOP,32'h100,32'h104,0));
        vecs.push_back(mk(0,0,1,0,0,32'h0,1,tag(32'h20), 0,32'h20, NOP,32'h100,32'h104,0));
        vecs.push_back(mk(0,0,1,0,0,32'h0,0,32'h0, 0,32'h24, NOP,32'h100,32'h104,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 0,32'h24, tag(32'h20),32'h20,32'h24,1));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h24, NOP,32'h20,32'h24,0));
        // FlushD with the hold buffer full: 0x24 must never reach Decode
        vecs.push_back(mk(0,0,1,0,0,32'h0,1,tag(32'h24), 0,32'h24, NOP,32'h20,32'h24,0));
        vecs.push_back(mk(0,0,1,1,0,32'h0,0,32'h0, 0,32'h28, NOP,32'h20,32'h24,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h28, NOP,32'h20,32'h24,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'h28), 0,32'h28, tag(32'h28),32'h28,32'h2C,1));
        // PC wraparound at the top of the address space
        vecs.push_back(mk(0,0,0,0,1,32'hFFFF_FFFC,0,32'h0, 0,32'h2C, NOP,32'h28,32'h2C,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'hFFFF_FFFC, NOP,32'h28,32'h2C,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'hFFFF_FFFC), 0,32'hFFFF_FFFC, tag(32'hFFFF_FFFC),32'hFFFF_FFFC,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h0, NOP,32'hFFFF_FFFC,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'h0), 0,32'h0, tag(32'h0),32'h0,32'h4,1));
        // StallF holds off issue; stray rvalid in ISSUE ignored
        vecs.push_back(mk(0,1,0,0,0,32'h0,0,32'h0, 0,32'h4, NOP,32'h0,32'h4,0));
        vecs.push_back(mk(0,1,0,0,0,32'h0,1,32'hDEAD_BEEF, 0,32'h4, NOP,32'h0,32'h4,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h4, NOP,32'h0,32'h4,0));
        // reset with a request in flight; the stale response is ignored
        vecs.push_back(mk(1,0,0,0,0,32'h0,0,32'h0, 0,32'h0, NOP,32'h0,32'h0,0));
        vecs.push_back(mk(0,1,0,0,0,32'h0,1,32'hDEAD_BEEF, 0,32'h0, NOP,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h0, NOP,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1,tag(32'h0), 0,32'h0, tag(32'h0),32'h0,32'h4,1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i != 0, $sformatf("row%0d", i));
        end

        // Redirect into DROP, redirect again while dropping; last target wins.
        apply(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h4, NOP,32'h0,32'h4,0), 1'b1, "drop_issue");
        apply(mk(0,0,0,0,1,32'h300,0,32'h0, 0,32'h4, NOP,32'h0,32'h4,0), 1'b1, "drop_enter");
        apply(mk(0,0,0,0,1,32'h400,0,32'h0, 0,32'h300, NOP,32'h0,32'h4,0), 1'b1, "drop_retarget");
        apply(mk(0,0,0,0,0,32'h0,1,tag(32'h4), 0,32'h400, NOP,32'h0,32'h4,0), 1'b1, "drop_discard");
        apply(mk(0,0,0,0,0,32'h0,0,32'h0, 1,32'h400, NOP,32'h0,32'h4,0), 1'b1, "drop_reissue");
        apply(mk(0,0,0,0,0,32'h0,1,tag(32'h400), 0,32'h400, tag(32'h400),32'h400,32'h404,1), 1'b1, "drop_resp");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core. Owns PCF, issues single-outstanding requests to a variable-latency instruction memory, and presents InstrD/PCD/PCPlus4D to Decode. Consumes StallF/StallD/FlushD from the hazard unit and PCSrcE/PCTargetE from Execute. Inserts NOP bubbles into Decode while memory is slow.

## Interface
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- StallF  in  1  hazard: hold PCF, no new issue
- StallD  in  1  hazard: hold IF/ID register
- FlushD  in  1  hazard: clear IF/ID register and hold buffer
- PCSrcE  in  1  taken branch/jump redirect
- PCTargetE  in  XLEN  redirect target
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  XLEN  request address, valid while imem_req
- imem_rvalid  in  1  response valid, ≥1 cycle after imem_req
- imem_rdata  in  32  response instruction
- InstrD  out  32  instruction to Decode
- PCD  out  XLEN  PC of InstrD
- PCPlus4D  out  XLEN  PCD+4
- ValidD  out  1  InstrD is real (0 = bubble)

## Operation
- States: ISSUE, WAIT, DROP. Reset → ISSUE, PCF=RESET_PC, hold buffer empty.
- ISSUE: PCSrcE → PCF<=PCTargetE, no request, stay. Else if !StallF and hold empty → imem_req=1, imem_addr=PCF, → WAIT. Else idle.
- WAIT, imem_rvalid & !PCSrcE: response routed to IF/ID if !StallD, else into hold buffer; PCF<=PCF+4; → ISSUE.
- WAIT, imem_rvalid & PCSrcE: response discarded; PCF<=PCTargetE; → ISSUE.
- WAIT, PCSrcE & !imem_rvalid: PCF<=PCTargetE; → DROP.
- DROP: next imem_rvalid discarded → ISSUE; further PCSrcE updates PCF.
- IF/ID priority: reset > FlushD > StallD (hold) > load. Load source: hold buffer if full (then empties), else WAIT response, else bubble (InstrD=32'h0000_0013, ValidD=0, PCD/PCPlus4D unchanged).
- FlushD: InstrD=NOP, ValidD=0, hold buffer emptied same edge.
- PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] of PCTargetE passed through unchecked.
- imem_rvalid outside WAIT/DROP ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, InstrD=32'h0000_0013, PCD=0, PCPlus4D=0, ValidD=0.
- imem_req/imem_addr combinational from state/PCF (plus chain path below); all other outputs registered.
- Latency-1 memory, no chaining: issue cycle t, rvalid t+1, InstrD valid after edge t+1, next issue t+2 → 1 instr / 2 cycles.
- Redirect latency: PCSrcE in cycle t → request to PCTargetE no earlier than t+1 (ISSUE) or after drop completes (DROP).
- reset mid-request: state → ISSUE; in-flight response arriving after reset ignored (state not WAIT/DROP until next issue). Memory must not return stale data after a new issue; bench enforces.

## Configuration
- FETCH_CHAIN_EN defined: in WAIT, imem_rvalid & !PCSrcE & !StallF & response going direct to IF/ID → imem_req=1, imem_addr=PCF+4 same cycle, stay WAIT; latency-1 memory sustains 1 instr/cycle.
- Undefined: always return to ISSUE between requests, behaviour as above.

## Structure
- riscv_pkg: XLEN, NOP_INSTR (32'h0000_0013), fetch state enum.
- One sub-module: fetch_hold_buf (single-entry instr+PC buffer with push/pop/clear, full flag).

## Test plan
- Reset, memory latency 1, rdata=PC-tagged → requests 0x0,0x4,0x8; InstrD sequence 0x0,bubble,0x4,bubble (chain off) / 0x0,0x4,0x8 back-to-back (chain on).
- PCSrcE=1, PCTargetE=0x100 while WAIT at 0x8, rvalid two cycles later → that response discarded, next imem_addr=0x100, no ValidD for 0x8.
- PCSrcE and imem_rvalid same cycle at PC 0x10 → response dropped, PCF=PCTargetE, ValidD stays 0.
- StallD=1 when response for 0x20 arrives → held in buffer, InstrD unchanged; StallD drops → InstrD=mem[0x20], PCD=0x20, PCPlus4D=0x24.
- FlushD with hold buffer full → InstrD=0x00000013, ValidD=0, buffer empty, held instruction never appears.
- PCTargetE=0xFFFF_FFFC → after response, next imem_addr=0x0000_0000.
